// File: rtl/cram_row_writer.sv
// cram_row_writer
//   Configuration-memory write stage for the ice384 CRAM array. It consumes a
//   byte-wide command/data stream, assembles one row frame and then drives the
//   bit-line bus, word-line address and a timed word-line enable so the CRAM
//   cells of the addressed row capture the frame.
//
//   Commands accepted in IDLE:
//     0x00 NOP, 0x01 SET_ROW (two address bytes follow, MSB first),
//     0x02 WRITE_FRAME (FRAME_BYTES data bytes follow), anything else -> ERR.
//
// Ports
//   CLK        sole clock, rising edge
//   RST        synchronous, active-high reset
//   DIN        command/data byte
//   DIN_VALID  DIN valid
//   DIN_READY  block accepts DIN this cycle
//   BL         frame bit-line data (first byte ends in the top byte)
//   WL_ADDR    current row address
//   WL_EN      word-line write enable, high WR_PULSE cycles per row
//   BUSY       high in any state other than IDLE
//   DONE       one-cycle pulse after each completed row write
//   ERR        sticky protocol error
//   ERR_CLR    clears ERR (a simultaneous new error wins)
module cram_row_writer #(
  parameter int unsigned FRAME_BYTES = 4,
  parameter int unsigned ROW_W       = 8,
  parameter int unsigned NUM_ROWS    = 144,
  parameter int unsigned WR_PULSE    = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               DIN,
  input  logic                     DIN_VALID,
  output logic                     DIN_READY,
  output logic [8*FRAME_BYTES-1:0] BL,
  output logic [ROW_W-1:0]         WL_ADDR,
  output logic                     WL_EN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR,
  input  logic                     ERR_CLR
);

  localparam int unsigned BLW = 8 * FRAME_BYTES;
  localparam int unsigned CW  = $clog2(FRAME_BYTES + 1);
  localparam int unsigned PW  = $clog2(WR_PULSE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_PRECHARGE, S_PULSE, S_RECOVER
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [BLW-1:0]    bl_d;
  logic [ROW_W-1:0]  addr_d;
  logic              ready_d, wlen_d, busy_d, done_d, err_d;
  logic              err_set;
  logic              accept;
  logic [ROW_W-1:0]  new_row;
  logic              row_ok;

  assign accept  = DIN_VALID && DIN_READY;
  // Address bits above ROW_W are dropped before the range check.
  assign new_row = ROW_W'({hi_q, DIN});
  assign row_ok  = {1'b0, new_row} < (ROW_W + 1)'(NUM_ROWS);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    bcnt_d  = bcnt_q;
    pcnt_d  = pcnt_q;
    bl_d    = BL;
    addr_d  = WL_ADDR;
    done_d  = 1'b0;
    err_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (DIN)
            8'h00: state_d = S_IDLE;
            8'h01: state_d = S_ADDR_HI;
            8'h02: begin
              bcnt_d  = '0;
              state_d = S_DATA;
            end
            default: err_set = 1'b1;
          endcase
        end
      end
      S_ADDR_HI: begin
        if (accept) begin
          hi_d    = DIN;
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (accept) begin
          if (row_ok) addr_d  = new_row;
          else        err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (accept) begin
          bl_d = (BL << 8) | BLW'(DIN);
          if (bcnt_q == CW'(FRAME_BYTES - 1)) state_d = S_PRECHARGE;
          else                                bcnt_d  = bcnt_q + 1'b1;
        end
      end
      S_PRECHARGE: begin
        pcnt_d  = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (pcnt_q == PW'(WR_PULSE - 1)) state_d = S_RECOVER;
        else                             pcnt_d  = pcnt_q + 1'b1;
      end
      S_RECOVER: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        addr_d  = (WL_ADDR == ROW_W'(NUM_ROWS - 1)) ? '0 : WL_ADDR + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    ready_d = (state_d == S_IDLE) || (state_d == S_ADDR_HI) ||
              (state_d == S_ADDR_LO) || (state_d == S_DATA);
    busy_d  = (state_d != S_IDLE);
    wlen_d  = (state_d == S_PULSE);
    err_d   = err_set | (ERR & ~ERR_CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      bcnt_q    <= '0;
      pcnt_q    <= '0;
      BL        <= '0;
      WL_ADDR   <= '0;
      WL_EN     <= 1'b0;
      DIN_READY <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      bcnt_q    <= bcnt_d;
      pcnt_q    <= pcnt_d;
      BL        <= bl_d;
      WL_ADDR   <= addr_d;
      WL_EN     <= wlen_d;
      DIN_READY <= ready_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ERR       <= err_d;
    end
  end

endmodule

// File: tb/tb_cram_row_writer.sv
module tb_cram_row_writer;

  localparam int unsigned FRAME_BYTES = 4;
  localparam int unsigned ROW_W       = 8;
  localparam int unsigned NUM_ROWS    = 144;
  localparam int unsigned WR_PULSE    = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DIN = '0;
  logic        DIN_VALID = 1'b0;
  logic        DIN_READY;
  logic [31:0] BL;
  logic [7:0]  WL_ADDR;
  logic        WL_EN, BUSY, DONE, ERR;
  logic        ERR_CLR = 1'b0;

  cram_row_writer #(
    .FRAME_BYTES(FRAME_BYTES), .ROW_W(ROW_W),
    .NUM_ROWS(NUM_ROWS), .WR_PULSE(WR_PULSE)
  ) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .BL(BL), .WL_ADDR(WL_ADDR), .WL_EN(WL_EN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] bl;
    logic [7:0]  nxt;
  } wr_t;

  wr_t exp_q[$];
  wr_t done_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  abort  = 1'b0;

  logic [7:0] m_addr = '0;
  logic       m_err  = 1'b0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_wl = 1'b0;
  int          run = 0;
  int          lowcnt = 0;
  bit          moved = 1'b0;
  logic [31:0] cur_bl;
  logic [7:0]  cur_addr;

  always @(negedge CLK) begin
    wr_t e;
    if (mon_en) begin
      if (WL_EN) begin
        if (!prev_wl) begin
          cur_bl = BL; cur_addr = WL_ADDR; run = 1; moved = 1'b0;
        end else begin
          run++;
          if (BL !== cur_bl || WL_ADDR !== cur_addr) moved = 1'b1;
        end
      end else if (prev_wl) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse actual=pulse required=none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (!abort) begin
            chk("pulse_len",    64'(run),      64'(WR_PULSE));
            chk("pulse_addr",   64'(cur_addr), 64'(e.addr));
            chk("pulse_bl",     64'(cur_bl),   64'(e.bl));
            chk("pulse_stable", 64'(moved),    64'(0));
            done_q.push_back(e);
          end
        end
      end
      prev_wl = WL_EN;

      if (DONE) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done actual=1 required=0 at %0t", $time);
        end else begin
          e = done_q.pop_front();
          chk("done_addr",  64'(WL_ADDR),   64'(e.nxt));
          chk("done_ready", 64'(DIN_READY), 64'(1));
        end
      end

      if (!DIN_READY) lowcnt++;
      else if (lowcnt != 0) begin
        if (!abort) chk("ready_low", 64'(lowcnt), 64'(WR_PULSE + 2));
        lowcnt = 0;
        abort  = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input bit clr, input bit keep);
    int w;
    w = 0;
    @(negedge CLK);
    DIN = b; DIN_VALID = 1'b1; ERR_CLR = clr;
    while (!DIN_READY && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!DIN_READY) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_ready required=ready at %0t", $time);
    end
    @(posedge CLK);
    #1;
    ERR_CLR = 1'b0;
    if (!keep) DIN_VALID = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b, input bit clr, input bit keep);
    bit set;
    send(b, clr, keep);
    set   = (b > 8'h02);
    m_err = set | (m_err & ~clr);
  endtask

  task automatic set_row(input logic [15:0] a, input bit keep);
    logic [ROW_W-1:0] r;
    send(8'h01, 1'b0, 1'b1);
    send(a[15:8], 1'b0, 1'b1);
    send(a[7:0], 1'b0, keep);
    r = a[ROW_W-1:0];
    if (int'(r) < NUM_ROWS) m_addr = r;
    else                    m_err  = 1'b1;
  endtask

  task automatic write_frame(input logic [31:0] d, input int gap, input bit keep);
    wr_t e;
    int  bad;
    e.addr = m_addr;
    e.bl   = d;
    e.nxt  = (int'(m_addr) == NUM_ROWS - 1) ? 8'd0 : m_addr + 8'd1;
    exp_q.push_back(e);
    m_addr = e.nxt;
    send(8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = d[31 - 8*i -: 8];
      if (i == 1 && gap > 0) begin
        send(b, 1'b0, 1'b0);
        bad = 0;
        repeat (gap) begin
          @(negedge CLK);
          if (WL_EN || !BUSY || !DIN_READY) bad++;
        end
        chk("stall_hold", 64'(bad), 64'(0));
      end else begin
        send(b, 1'b0, (i == 3) ? keep : 1'b1);
      end
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge CLK);
    while ((BUSY || exp_q.size() != 0 || done_q.size() != 0) && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("idle_reached", 64'(BUSY), 64'(0));
  endtask

  task automatic chk_state(input string n);
    @(negedge CLK);
    chk({n, "_addr"}, 64'(WL_ADDR), 64'(m_addr));
    chk({n, "_err"},  64'(ERR),     64'(m_err));
  endtask

  initial begin
    int w, bad;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 64'(DIN_READY), 64'(1));
    chk("rst_bl",    64'(BL),        64'(0));
    chk("rst_addr",  64'(WL_ADDR),   64'(0));
    chk("rst_wlen",  64'(WL_EN),     64'(0));
    chk("rst_busy",  64'(BUSY),      64'(0));
    chk("rst_done",  64'(DONE),      64'(0));
    chk("rst_err",   64'(ERR),       64'(0));
    mon_en = 1'b1;

    // basic row write
    set_row(16'h0005, 1'b0);
    chk_state("setrow5");
    write_frame(32'hDEADBEEF, 0, 1'b0);
    wait_idle();
    chk_state("after5");

    // last row wraps to 0
    set_row(16'd143, 1'b0);
    write_frame($urandom, 0, 1'b0);
    wait_idle();
    chk_state("wrap");

    // error handling
    set_row(16'h0090, 1'b0);
    chk_state("oor");
    cmd(8'h07, 1'b0, 1'b0);
    chk_state("badcmd");
    @(negedge CLK); ERR_CLR = 1'b1;
    @(negedge CLK); ERR_CLR = 1'b0;
    m_err = 1'b0;
    chk_state("errclr");
    cmd(8'h07, 1'b1, 1'b0);
    chk_state("set_wins");
    cmd(8'h00, 1'b1, 1'b0);
    chk_state("clr_nop");

    // valid gap mid-frame
    set_row(16'd20, 1'b0);
    write_frame($urandom, 10, 1'b0);
    wait_idle();
    chk_state("gap");

    // back-to-back frames, valid held high
    set_row(16'd30, 1'b1);
    write_frame($urandom, 0, 1'b1);
    write_frame($urandom, 0, 1'b0);
    wait_idle();
    chk_state("b2b");

    // reset during second pulse cycle
    set_row(16'd50, 1'b0);
    abort = 1'b1;
    write_frame($urandom, 0, 1'b0);
    w = 0;
    while (!WL_EN && w < 50) begin
      @(negedge CLK);
      w++;
    end
    chk("abort_pulse_seen", 64'(WL_EN), 64'(1));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_wlen", 64'(WL_EN),     64'(0));
    chk("abort_addr", 64'(WL_ADDR),   64'(0));
    chk("abort_bl",   64'(BL),        64'(0));
    chk("abort_done", 64'(DONE),      64'(0));
    chk("abort_rdy",  64'(DIN_READY), 64'(1));
    m_addr = '0; m_err = 1'b0;
    done_q.delete();
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (DONE) bad++;
    end
    chk("abort_no_done", 64'(bad), 64'(0));
    cmd(8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    chk("nop_busy", 64'(BUSY), 64'(0));
    chk("nop_err",  64'(ERR),  64'(0));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int op;
      bit keep;
      op   = $urandom_range(0, 9);
      keep = ($urandom_range(0, 1) == 1);
      if (op <= 1) begin
        logic [7:0] c;
        c = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(3, 255));
        cmd(c, ($urandom_range(0, 2) == 0), keep);
        if (!keep) chk_state("rnd_cmd");
      end else if (op <= 3) begin
        logic [15:0] a;
        a = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 170))};
        set_row(a, keep);
        if (!keep) chk_state("rnd_row");
      end else begin
        write_frame($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, keep);
      end
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    wait_idle();
    chk("drain_exp",  64'(exp_q.size()),  64'(0));
    chk("drain_done", 64'(done_q.size()), 64'(0));
    chk_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
